// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: access-size encodings, FSM states
// and the load extension helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        SwhbIllegal = 2'b00,
        SwhbWord    = 2'b01,
        SwhbHalf    = 2'b10,
        SwhbByte    = 2'b11
    } swhb_e;

    typedef enum logic [1:0] {
        LwhbWord    = 2'b00,
        LwhbHalf    = 2'b01,
        LwhbByte    = 2'b10,
        LwhbIllegal = 2'b11
    } lwhb_e;

    typedef enum logic [1:0] {
        ArbIdle  = 2'b00,
        ArbIBusy = 2'b01,
        ArbDBusy = 2'b10,
        ArbDErr  = 2'b11
    } arb_state_e;

    // Zero- or sign-extends a half (or the low byte of val when is_byte) to 32 bits.
    function automatic logic [31:0] extend(input logic [15:0] val, input logic is_byte,
                                           input logic uns);
        logic sign;
        sign = uns ? 1'b0 : (is_byte ? val[7] : val[15]);
        return is_byte ? {{24{sign}}, val[7:0]} : {{16{sign}}, val};
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store mask/replication, load extract/extend and alignment check.
module mem_lane_fmt
    import mem_port_arbiter_pkg::*;
(
    input  logic        i_we,
    input  logic [1:0]  i_swhb,
    input  logic [1:0]  i_lwhb,
    input  logic        i_lunsigned,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];

    always_comb begin
        o_wmask      = 4'b0000;
        o_wdata      = i_wdata;
        o_rdata      = i_rdata;
        o_misaligned = 1'b0;
        if (i_we) begin
            case (swhb_e'(i_swhb))
                SwhbWord: begin
                    o_wmask      = 4'b1111;
                    o_misaligned = (i_addr_lo != 2'b00);
                end
                SwhbHalf: begin
                    o_wmask      = 4'b0011 << {i_addr_lo[1], 1'b0};
                    o_wdata      = {2{i_wdata[15:0]}};
                    o_misaligned = i_addr_lo[0];
                end
                SwhbByte: begin
                    o_wmask = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                default: o_misaligned = 1'b1;
            endcase
        end else begin
            case (lwhb_e'(i_lwhb))
                LwhbWord: o_misaligned = (i_addr_lo != 2'b00);
                LwhbHalf: begin
                    o_rdata      = extend(w_half, 1'b0, i_lunsigned);
                    o_misaligned = i_addr_lo[0];
                end
                LwhbByte: o_rdata = extend({8'h00, w_byte}, 1'b1, i_lunsigned);
                default:  o_misaligned = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (I) and load/store (D) with fixed
// D priority, bounded fetch starvation and one outstanding transaction.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [31:0]   i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [1:0]    d_swhb,
    input  logic [1:0]    d_lwhb,
    input  logic          d_lunsigned,
    output logic [31:0]   d_rdata,
    output logic          d_ack,
    output logic          d_err,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    output logic [3:0]    m_wmask,
    input  logic [31:0]   m_rdata,
    input  logic          m_ready,
    output logic          stall_if,
    output logic          stall_mem
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] StarveMax = CW'(STARVE_MAX);

    arb_state_e    r_state, w_state_d;
    logic [CW-1:0] r_starve_cnt, w_starve_d;
    logic          r_m_we;
    logic [AW-1:0] r_m_addr;
    logic [31:0]   r_m_wdata;
    logic [3:0]    r_m_wmask;

    logic          w_grant_i, w_grant_d;
    logic [3:0]    w_fmt_wmask;
    logic [31:0]   w_fmt_wdata, w_fmt_rdata;
    logic          w_misaligned;
    logic          w_unused_addr_lo;

    assign w_unused_addr_lo = ^i_addr[1:0];

    // Requester holds its inputs until ack, so one formatter serves grant and completion.
    mem_lane_fmt u_lane_fmt (
        .i_we         (d_we),
        .i_swhb       (d_swhb),
        .i_lwhb       (d_lwhb),
        .i_lunsigned  (d_lunsigned),
        .i_addr_lo    (d_addr[1:0]),
        .i_wdata      (d_wdata),
        .i_rdata      (m_rdata),
        .o_wmask      (w_fmt_wmask),
        .o_wdata      (w_fmt_wdata),
        .o_rdata      (w_fmt_rdata),
        .o_misaligned (w_misaligned)
    );

    always_comb begin
        w_state_d  = r_state;
        w_starve_d = r_starve_cnt;
        w_grant_i  = 1'b0;
        w_grant_d  = 1'b0;
        case (r_state)
            ArbIdle: begin
                if (d_req && (r_starve_cnt < StarveMax)) w_grant_d = 1'b1;
                else if (i_req)                          w_grant_i = 1'b1;
                else if (d_req)                          w_grant_d = 1'b1;
                if (w_grant_d) w_state_d = w_misaligned ? ArbDErr : ArbDBusy;
                if (w_grant_i) w_state_d = ArbIBusy;
                if (w_grant_i || !i_req) begin
                    w_starve_d = '0;
                end else if (w_grant_d && (r_starve_cnt < StarveMax)) begin
                    w_starve_d = r_starve_cnt + 1'b1;
                end
            end
            ArbIBusy, ArbDBusy: if (m_ready) w_state_d = ArbIdle;
            default:            w_state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ArbIdle;
            r_starve_cnt <= '0;
            r_m_we       <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_m_wmask    <= '0;
        end else begin
            r_state      <= w_state_d;
            r_starve_cnt <= w_starve_d;
            if (w_grant_i) begin
                r_m_we    <= 1'b0;
                r_m_addr  <= {i_addr[AW-1:2], 2'b00};
                r_m_wdata <= '0;
                r_m_wmask <= 4'b0000;
            end else if (w_grant_d && !w_misaligned) begin
                r_m_we    <= d_we;
                r_m_addr  <= {d_addr[AW-1:2], 2'b00};
                r_m_wdata <= w_fmt_wdata;
                r_m_wmask <= w_fmt_wmask;
            end
        end
    end

    assign m_req     = (r_state == ArbIBusy) || (r_state == ArbDBusy);
    assign m_we      = r_m_we;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign m_wmask   = r_m_wmask;
    assign i_ack     = (r_state == ArbIBusy) && m_ready;
    assign i_rdata   = m_rdata;
    assign d_err     = (r_state == ArbDErr);
    assign d_ack     = ((r_state == ArbDBusy) && m_ready) || d_err;
    assign d_rdata   = w_fmt_rdata;
    assign stall_if  = i_req && !i_ack;
    assign stall_mem = d_req && !d_ack;

endmodule
